// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the icache/dcache memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr.sv
// ============================================================================
// Module      : mem_arb_rr
// Description : Combinational 2-way round-robin picker, one-hot result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] pick
);

  // A tie goes to whichever port did not win last time.
  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one line-wide memory port between icache (p0) and dcache (p1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [LINE_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [LINE_W-1:0] p0_data_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [LINE_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [LINE_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_data;
  logic [CNT_W-1:0]  r_wdog_cnt;
  logic              r_timeout;
  logic [1:0]        w_pick;
  logic              w_busy;
  logic              w_win;
  logic              w_win_port;

  mem_arb_rr u_rr (
    .req        ({p1_enable_i, p0_enable_i}),
    .last_grant (r_last_grant),
    .pick       (w_pick)
  );

  assign w_busy     = (r_state == BUSY);
  assign w_win      = (r_state == IDLE) && (|w_pick);
  assign w_win_port = w_pick[PORT_DCACHE];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_win)     w_state_next = BUSY;
      BUSY:    if (mem_ack_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Transaction fields are captured once at grant and held until the next grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner      <= PORT_ICACHE;
      r_last_grant <= PORT_ICACHE;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else if (w_win) begin
      r_owner      <= w_win_port;
      r_last_grant <= w_win_port;
      r_mem_write  <= w_win_port ? p1_write_i : p0_write_i;
      r_mem_addr   <= w_win_port ? p1_addr_i  : p0_addr_i;
      r_mem_data   <= w_win_port ? p1_data_i  : p0_data_i;
    end
  end

  // Watchdog only flags a stalled memory; the transaction is never aborted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wdog_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_win) begin
      r_wdog_cnt <= '0;
    end else if (w_busy && !mem_ack_i && (r_wdog_cnt != C_TIMEOUT)) begin
      r_wdog_cnt <= r_wdog_cnt + 1'b1;
      if ((TIMEOUT != 0) && (r_wdog_cnt + 1'b1 == C_TIMEOUT)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign mem_enable_o = w_busy;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  assign timeout_o    = r_timeout;
  assign grant_o      = w_busy ? (r_owner ? 2'b10 : 2'b01) : 2'b00;

  assign p0_ack_o  = w_busy && mem_ack_i && (r_owner == PORT_ICACHE);
  assign p1_ack_o  = w_busy && mem_ack_i && (r_owner == PORT_DCACHE);
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;

endmodule

`default_nettype wire
